// File: rtl/display_source_scheduler.sv
// Picks which accelerometer axis (X/Y/Z) drives the shared 2-digit display:
// dwell-timed rotation, debounced manual stepping, and a threshold alert that pins an axis.
module display_source_scheduler #(
  parameter int unsigned DWELL_CYCLES    = 100_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter logic [7:0]  ALERT_THRESHOLD = 8'd90
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] x_data,
  input  logic [7:0] y_data,
  input  logic [7:0] z_data,
  input  logic       x_valid,
  input  logic       y_valid,
  input  logic       z_valid,
  input  logic       mode,
  input  logic       next_btn,
  output logic [7:0] data_out,
  output logic [1:0] ch_sel,
  output logic       alert,
  output logic       update,
  output logic       fsm_state
);

  localparam int unsigned DW  = $clog2(DWELL_CYCLES + 1);
  localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0]  DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [DW-1:0]  DWELL_FULL = DW'(DWELL_CYCLES);
  localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {ST_NORMAL = 1'b0, ST_ALERT = 1'b1} state_t;

  state_t         state, state_next;
  logic [7:0]     x_reg, y_reg, z_reg;
  logic [7:0]     shadow_sel, alert_ch_val;
  logic           mode_s1, mode_sync, mode_d, mode_change;
  logic           btn_s1, btn_s2, btn_level, next_pulse;
  logic [DBW-1:0] db_cnt;
  logic [DW-1:0]  dwell_cnt, dwell_next;
  logic [DW-1:0]  hold_cnt, hold_next;
  logic [1:0]     ch_sel_next, ch_sel_adv;
  logic [1:0]     alert_ch, alert_ch_next, alert_idx;
  logic           over_x, over_y, over_z, alert_any;

  // Axis strobes are single-cycle valid with no ready: data is captured on the
  // edge where its valid is high and is never back-pressured.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_reg <= '0;
      y_reg <= '0;
      z_reg <= '0;
    end else begin
      if (x_valid) x_reg <= x_data;
      if (y_valid) y_reg <= y_data;
      if (z_valid) z_reg <= z_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_s1   <= 1'b0;
      mode_sync <= 1'b0;
      mode_d    <= 1'b0;
      btn_s1    <= 1'b0;
      btn_s2    <= 1'b0;
    end else begin
      mode_s1   <= mode;
      mode_sync <= mode_s1;
      mode_d    <= mode_sync;
      btn_s1    <= next_btn;
      btn_s2    <= btn_s1;
    end
  end

  assign mode_change = mode_sync ^ mode_d;

  // A level is accepted once it has differed from the accepted level for
  // DEBOUNCE_CYCLES consecutive cycles; only a press yields a NEXT pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_cnt     <= '0;
      btn_level  <= 1'b0;
      next_pulse <= 1'b0;
    end else if (btn_s2 != btn_level) begin
      if (db_cnt == DB_LAST) begin
        db_cnt     <= '0;
        btn_level  <= btn_s2;
        next_pulse <= btn_s2;
      end else begin
        db_cnt     <= db_cnt + DBW'(1);
        next_pulse <= 1'b0;
      end
    end else begin
      db_cnt     <= '0;
      next_pulse <= 1'b0;
    end
  end

  assign over_x    = x_reg > ALERT_THRESHOLD;
  assign over_y    = y_reg > ALERT_THRESHOLD;
  assign over_z    = z_reg > ALERT_THRESHOLD;
  assign alert_any = over_x | over_y | over_z;
  assign alert_idx = over_x ? 2'd0 : (over_y ? 2'd1 : 2'd2);
  assign ch_sel_adv = (ch_sel == 2'd2) ? 2'd0 : ch_sel + 2'd1;

  always_comb begin
    case (ch_sel)
      2'd0:    shadow_sel = x_reg;
      2'd1:    shadow_sel = y_reg;
      2'd2:    shadow_sel = z_reg;
      default: shadow_sel = 8'd0;
    endcase
  end

  always_comb begin
    case (alert_ch)
      2'd0:    alert_ch_val = x_reg;
      2'd1:    alert_ch_val = y_reg;
      2'd2:    alert_ch_val = z_reg;
      default: alert_ch_val = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_NORMAL;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_NORMAL: if (alert_any) state_next = ST_ALERT;
      ST_ALERT:  if (hold_cnt == DWELL_FULL && alert_ch_val <= ALERT_THRESHOLD)
                   state_next = ST_NORMAL;
      default:   state_next = ST_NORMAL;
    endcase
  end

  always_comb begin
    alert     = (state == ST_ALERT);
    fsm_state = state;
  end

  // Alert entry outranks a mode change, which outranks NEXT / dwell advance.
  always_comb begin
    ch_sel_next   = ch_sel;
    dwell_next    = dwell_cnt;
    hold_next     = hold_cnt;
    alert_ch_next = alert_ch;
    case (state)
      ST_NORMAL: begin
        if (alert_any) begin
          alert_ch_next = alert_idx;
          ch_sel_next   = alert_idx;
          hold_next     = '0;
          dwell_next    = '0;
        end else if (mode_change) begin
          dwell_next = '0;
        end else if (mode_sync) begin
          dwell_next = '0;
          if (next_pulse) ch_sel_next = ch_sel_adv;
        end else if (next_pulse || dwell_cnt == DWELL_LAST) begin
          ch_sel_next = ch_sel_adv;
          dwell_next  = '0;
        end else begin
          dwell_next = dwell_cnt + DW'(1);
        end
      end
      ST_ALERT: begin
        dwell_next = '0;
        if (hold_cnt != DWELL_FULL) hold_next = hold_cnt + DW'(1);
      end
      default: begin
        dwell_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_sel    <= 2'd0;
      dwell_cnt <= '0;
      hold_cnt  <= '0;
      alert_ch  <= 2'd0;
      data_out  <= 8'd0;
      update    <= 1'b0;
    end else begin
      ch_sel    <= ch_sel_next;
      dwell_cnt <= dwell_next;
      hold_cnt  <= hold_next;
      alert_ch  <= alert_ch_next;
      data_out  <= shadow_sel;
      update    <= (ch_sel_next != ch_sel);
    end
  end

endmodule

// File: doc/display_source_scheduler.md
Name: display_source_scheduler

Overview:
- Shares the single 2-digit seven-segment display between the three accelerometer axis values (X, Y, Z) produced by the SPI readout path.
- Latches the latest sample per axis and selects which axis drives the display's 8-bit data input:
  - auto mode: rotates X -> Y -> Z on a dwell timer;
  - manual mode: steps axes on a debounced push-button.
- A threshold alert pre-empts the rotation and pins the offending axis on screen.

Parameters:
- DWELL_CYCLES, 100_000_000, clock cycles per displayed axis in auto mode and minimum alert hold time (1 s at 100 MHz).
- DEBOUNCE_CYCLES, 1_000_000, cycles the synchronized button level must be stable before it is accepted.
- ALERT_THRESHOLD, 90, 8-bit unsigned; an axis value strictly greater than this raises an alert.

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- X_DATA / Y_DATA / Z_DATA  in  8 each  unsigned axis magnitudes from the SPI readout
- X_VALID / Y_VALID / Z_VALID  in  1 each  one-cycle strobe; corresponding DATA is valid
- MODE  in  1  slide switch: 0 = auto rotate, 1 = manual; asynchronous, 2-FF synchronized internally
- NEXT_BTN  in  1  raw push-button, active-high, asynchronous
- DATA_OUT  out  8  value routed to the display's data input
- CH_SEL  out  2  displayed axis: 0 = X, 1 = Y, 2 = Z; the value 3 never appears
- ALERT  out  1  high while in the ALERT state
- UPDATE  out  1  one-cycle pulse whenever CH_SEL changes

Behaviour:
- Reset values (asynchronous on RESET_N low):
  - X_REG, Y_REG, Z_REG, DATA_OUT = 0; CH_SEL = 0; ALERT = 0; UPDATE = 0.
  - All counters = 0; state = NORMAL; synchronizer and debounced button level = 0.
- Shadow registers:
  - A VALID strobe loads the matching shadow register on that clock edge.
  - The three channels are independent; simultaneous strobes load all of them.
  - With no strobe, the register holds.
- Button path:
  - NEXT_BTN passes through a 2-FF synchronizer, then a debounce counter.
  - The counter resets on any change of the synchronized level; when it reaches DEBOUNCE_CYCLES the level is accepted.
  - A 0 -> 1 transition of the accepted level produces a one-cycle NEXT pulse. No pulse is produced on release.
- Pointer advance: CH_SEL wraps 0 -> 1 -> 2 -> 0.
- DATA_OUT:
  - DATA_OUT = shadow[CH_SEL], registered, giving 1-cycle latency after a CH_SEL change or a shadow update.
  - When a shadow load and a pointer change happen on the same edge, the next cycle shows the new pointer's post-load value.
- State NORMAL:
  - Auto mode (MODE_sync = 0):
    - The dwell counter runs 0..DWELL_CYCLES-1.
    - At terminal count the pointer advances and the counter returns to 0.
    - A NEXT pulse advances the pointer and clears the counter. NEXT and terminal count in the same cycle advance the pointer once only.
  - Manual mode (MODE_sync = 1):
    - The dwell counter is held at 0.
    - Only NEXT advances the pointer.
  - Any change of MODE_sync clears the dwell counter; the pointer holds.
  - Alert entry:
    - The alert check is evaluated on the shadow registers every cycle.
    - If any shadow > ALERT_THRESHOLD: latch alert_ch = lowest index exceeding, set CH_SEL = alert_ch, clear the hold counter, go to ALERT.
    - Alert entry has priority over NEXT and dwell advance in the same cycle.
- State ALERT:
  - ALERT = 1; CH_SEL stays at alert_ch; NEXT pulses are discarded; the dwell counter is held at 0.
  - The hold counter saturates at DWELL_CYCLES.
  - Exit to NORMAL when both hold counter == DWELL_CYCLES and shadow[alert_ch] <= ALERT_THRESHOLD.
  - On exit: CH_SEL stays at alert_ch, the dwell counter restarts at 0, ALERT drops on the same edge.
  - Other axes exceeding the threshold while in ALERT do not change alert_ch.
  - Re-entry is evaluated from the first NORMAL cycle after exit.
- UPDATE: asserted for exactly the one cycle following any edge on which CH_SEL changed value. An alert entry to the already-displayed axis produces no pulse.
- Reset mid-operation: RESET_N low returns every register to its reset value immediately, regardless of state or counter position.

Test Plan (DWELL_CYCLES=10, DEBOUNCE_CYCLES=4, ALERT_THRESHOLD=90):
- Auto rotation:
  - Stimulus: load X=12, Y=34, Z=56; MODE=0.
  - Required: CH_SEL 0 -> 1 -> 2 -> 0 every 10 cycles; DATA_OUT tracks 12/34/56 one cycle behind CH_SEL; UPDATE is a single pulse per step.
- Manual / debounce:
  - Stimulus: MODE=1; NEXT_BTN glitches high for 2 cycles, then is held high for 8 cycles, then released.
  - Required: the glitch is ignored; exactly one advance 0 -> 1, occurring 2 sync + 4 debounce cycles after the held press; no advance on release.
- Alert pre-emption:
  - Stimulus: auto mode, CH_SEL=0; Y_VALID with Y=95.
  - Required: the next edge gives CH_SEL=1 and ALERT=1.
  - Then Y=40 at hold count 3: ALERT remains until hold count 10, then exit with CH_SEL=1 and rotation resuming to 2 after 10 further cycles.
- Simultaneous alerts:
  - Stimulus: X=91 and Z=99 strobed in the same cycle.
  - Required: alert_ch=0; raising Y=100 during ALERT leaves CH_SEL=0; NEXT pulses during ALERT are ignored.
- Coincident events:
  - Stimulus: NEXT pulse on the dwell terminal cycle.
  - Required: single advance.
  - Stimulus: MODE toggled at dwell count 7.
  - Required: counter cleared, pointer unchanged.
- Async reset:
  - Stimulus: RESET_N low mid-ALERT at hold count 5, released off a clock edge.
  - Required: all outputs 0 immediately; state NORMAL; shadows 0; rotation restarts at X.
